// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: word type, RAM status and arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RamFree   = 2'd0,
    RamBusy   = 2'd1,
    RamAccess = 2'd2,
    RamError  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    StIdle,
    StDGrant,
    StIGrant
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/response bus and shared RAM port seen by the two-core memory arbiter.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      [1:0] iREN;
  word_t     [1:0] iaddr;
  logic      [1:0] iwait;
  word_t     [1:0] iload;

  logic      [1:0] dREN;
  logic      [1:0] dWEN;
  word_t     [1:0] daddr;
  word_t     [1:0] dstore;
  logic      [1:0] dwait;
  word_t     [1:0] dload;

  logic            ramREN;
  logic            ramWEN;
  word_t           ramaddr;
  word_t           ramstore;
  word_t           ramload;
  ramstate_t       ramstate;

  // Arbiter side.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Caches and RAM side.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_select.sv
// Two-requester round-robin picker: on a tie the requester indexed by ptr_i wins.
module rr_select (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = (&req_i) ? ptr_i : req_i[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-core memory arbiter: dcache sequences hold the grant until released, icache is served one
// word per grant, and a saturating starvation counter lets a waiting icache outrank dcaches.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned NCORES       = 2,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic          CLK,
  input  logic          n_rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  typedef logic [SW-1:0] starve_t;

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_d_q, rr_d_d;
  logic              rr_i_q, rr_i_d;
  starve_t           starve_q [NCORES];
  starve_t           starve_d [NCORES];
  logic [NCORES-1:0] starved;
  logic              i_done;

  logic d_valid, d_idx;
  logic i_valid, i_idx;

  rr_select u_rr_d (
    .req_i         (bus.dREN | bus.dWEN),
    .ptr_i         (rr_d_q),
    .grant_valid_o (d_valid),
    .grant_idx_o   (d_idx)
  );

  rr_select u_rr_i (
    .req_i         (bus.iREN),
    .ptr_i         (rr_i_q),
    .grant_valid_o (i_valid),
    .grant_idx_o   (i_idx)
  );

  always_comb begin
    for (int c = 0; c < NCORES; c++) begin
      starved[c] = bus.iREN[c] && (starve_q[c] >= starve_t'(STARVE_LIMIT));
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d_d       = rr_d_q;
    rr_i_d       = rr_i_q;
    i_done       = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 2'b11;
    bus.dwait    = 2'b11;
    bus.iload    = '0;
    bus.dload    = '0;

    unique case (state_q)
      StIdle: begin
        if (|starved) begin
          owner_d = ~starved[0];
          state_d = StIGrant;
        end else if (d_valid) begin
          owner_d = d_idx;
          state_d = StDGrant;
        end else if (i_valid) begin
          owner_d = i_idx;
          state_d = StIGrant;
        end
      end

      StDGrant: begin
        if (bus.dREN[owner_q] | bus.dWEN[owner_q]) begin
          // A write takes precedence when both enables are held.
          bus.ramWEN   = bus.dWEN[owner_q];
          bus.ramREN   = bus.dREN[owner_q] & ~bus.dWEN[owner_q];
          bus.ramaddr  = bus.daddr[owner_q];
          bus.ramstore = bus.dstore[owner_q];
          if (bus.ramstate == RamAccess) begin
            bus.dwait[owner_q] = 1'b0;
            bus.dload[owner_q] = bus.ramload;
          end
        end else begin
          state_d = StIdle;
          rr_d_d  = ~owner_q;
        end
      end

      StIGrant: begin
        if (bus.iREN[owner_q]) begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr[owner_q];
          if (bus.ramstate == RamAccess) begin
            bus.iwait[owner_q] = 1'b0;
            bus.iload[owner_q] = bus.ramload;
            state_d            = StIdle;
            rr_i_d             = ~owner_q;
            i_done             = 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // A core that currently holds the icache grant neither ages nor clears until it completes.
  always_comb begin
    for (int c = 0; c < NCORES; c++) begin
      starve_d[c] = starve_q[c];
      if (!bus.iREN[c]) begin
        starve_d[c] = '0;
      end else if (i_done && (owner_q == 1'(c))) begin
        starve_d[c] = '0;
      end else if ((state_q == StIGrant) && (owner_q == 1'(c))) begin
        starve_d[c] = starve_q[c];
      end else if (starve_q[c] < starve_t'(STARVE_LIMIT)) begin
        starve_d[c] = starve_q[c] + starve_t'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      rr_d_q  <= 1'b0;
      rr_i_q  <= 1'b0;
      for (int c = 0; c < NCORES; c++) begin
        starve_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_d_q  <= rr_d_d;
      rr_i_q  <= rr_i_d;
      for (int c = 0; c < NCORES; c++) begin
        starve_q[c] <= starve_d[c];
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, locked dcache sequences, icache service,
// starvation override, write-over-read priority and asynchronous reset mid-transfer.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .NCORES       (2),
    .STARVE_LIMIT (16)
  ) dut (
    .CLK   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are checked 1-2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN     = '0;
    bus.iaddr    = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = RamFree;
  endtask

  task automatic do_reset();
    idle_inputs();
    n_rst = 1'b0;
    cyc();
    cyc();
    n_rst = 1'b1;
  endtask

  initial begin
    // Reset values
    idle_inputs();
    n_rst = 1'b0;
    cyc();
    chk("rst_iwait", 32'(bus.iwait), 32'h3);
    chk("rst_dwait", 32'(bus.dwait), 32'h3);
    chk("rst_ren", 32'(bus.ramREN), 32'h0);
    chk("rst_wen", 32'(bus.ramWEN), 32'h0);
    chk("rst_addr", bus.ramaddr, 32'h0);
    chk("rst_store", bus.ramstore, 32'h0);
    chk("rst_iload", bus.iload[0] | bus.iload[1], 32'h0);
    chk("rst_dload", bus.dload[0] | bus.dload[1], 32'h0);
    n_rst = 1'b1;

    // Core0 single dcache read, two BUSY cycles then ACCESS
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h100;
    bus.ramstate = RamBusy;
    #1 chk("t1_idle_ren", 32'(bus.ramREN), 32'h0);
    cyc();
    chk("t1_ren", 32'(bus.ramREN), 32'h1);
    chk("t1_addr", bus.ramaddr, 32'h100);
    chk("t1_busy_dwait", 32'(bus.dwait), 32'h3);
    cyc();
    chk("t1_busy2_dwait", 32'(bus.dwait), 32'h3);
    cyc();
    bus.ramstate = RamAccess;
    bus.ramload  = 32'hDEADBEEF;
    #1 chk("t1_dwait", 32'(bus.dwait), 32'h2);
    chk("t1_dload0", bus.dload[0], 32'hDEADBEEF);
    chk("t1_dload1", bus.dload[1], 32'h0);
    chk("t1_iwait", 32'(bus.iwait), 32'h3);
    bus.dREN[0] = 1'b0;
    #1 chk("t1_drop_ren", 32'(bus.ramREN), 32'h0);
    chk("t1_drop_dwait", 32'(bus.dwait), 32'h3);

    // Both cores write together; core0's 4-word sequence must not be interleaved
    do_reset();
    bus.dWEN      = 2'b11;
    bus.daddr[1]  = 32'h300;
    bus.dstore[0] = 32'h11;
    bus.dstore[1] = 32'h22;
    bus.ramstate  = RamAccess;
    cyc();
    for (int k = 0; k < 4; k++) begin
      bus.daddr[0] = 32'h200 + 32'(k * 4);
      #1 chk("t2_c0_addr", bus.ramaddr, 32'h200 + 32'(k * 4));
      chk("t2_c0_wen", 32'(bus.ramWEN), 32'h1);
      chk("t2_c0_store", bus.ramstore, 32'h11);
      chk("t2_c0_dwait", 32'(bus.dwait), 32'h2);
      cyc();
    end
    bus.dWEN[0] = 1'b0;
    #1 chk("t2_drop_wen", 32'(bus.ramWEN), 32'h0);
    chk("t2_drop_dwait", 32'(bus.dwait), 32'h3);
    cyc();
    chk("t2_idle_wen", 32'(bus.ramWEN), 32'h0);
    cyc();
    chk("t2_c1_addr", bus.ramaddr, 32'h300);
    chk("t2_c1_store", bus.ramstore, 32'h22);
    chk("t2_c1_dwait", 32'(bus.dwait), 32'h1);
    bus.dWEN[1] = 1'b0;
    cyc();

    // Core0 icache vs core1 dcache: D first, then I
    do_reset();
    bus.iREN[0]  = 1'b1;
    bus.iaddr[0] = 32'h40;
    bus.dREN[1]  = 1'b1;
    bus.daddr[1] = 32'h500;
    bus.ramstate = RamAccess;
    bus.ramload  = 32'hCAFE0001;
    cyc();
    chk("t3_d_addr", bus.ramaddr, 32'h500);
    chk("t3_d_dwait", 32'(bus.dwait), 32'h1);
    chk("t3_d_dload1", bus.dload[1], 32'hCAFE0001);
    chk("t3_d_iwait", 32'(bus.iwait), 32'h3);
    bus.dREN[1] = 1'b0;
    cyc();
    chk("t3_idle_ren", 32'(bus.ramREN), 32'h0);
    cyc();
    bus.ramload = 32'h12345678;
    #1 chk("t3_i_ren", 32'(bus.ramREN), 32'h1);
    chk("t3_i_addr", bus.ramaddr, 32'h40);
    chk("t3_i_iwait", 32'(bus.iwait), 32'h2);
    chk("t3_i_iload0", bus.iload[0], 32'h12345678);
    chk("t3_i_dwait", 32'(bus.dwait), 32'h3);
    bus.iREN[0] = 1'b0;
    cyc();

    // Core1 icache starves behind a long core0 dcache stream
    do_reset();
    bus.iREN[1]  = 1'b1;
    bus.iaddr[1] = 32'h80;
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h600;
    bus.ramstate = RamAccess;
    bus.ramload  = 32'hA5A5A5A5;
    for (int k = 0; k < 20; k++) begin
      cyc();
    end
    chk("t4_stream_addr", bus.ramaddr, 32'h600);
    chk("t4_stream_iwait", 32'(bus.iwait), 32'h3);
    bus.dREN[0] = 1'b0;
    cyc();
    bus.dREN[0] = 1'b1;
    #1 chk("t4_idle_ren", 32'(bus.ramREN), 32'h0);
    cyc();
    chk("t4_starved_addr", bus.ramaddr, 32'h80);
    chk("t4_starved_iwait", 32'(bus.iwait), 32'h1);
    chk("t4_starved_iload1", bus.iload[1], 32'hA5A5A5A5);
    chk("t4_starved_dwait", 32'(bus.dwait), 32'h3);
    bus.iREN[1] = 1'b0;
    cyc();
    cyc();
    chk("t4_d_after_addr", bus.ramaddr, 32'h600);
    bus.dREN[0] = 1'b0;
    cyc();

    // Read and write both set: write wins
    do_reset();
    bus.dREN[0]  = 1'b1;
    bus.dWEN[0]  = 1'b1;
    bus.daddr[0] = 32'h700;
    bus.ramstate = RamBusy;
    cyc();
    chk("t5_wen", 32'(bus.ramWEN), 32'h1);
    chk("t5_ren", 32'(bus.ramREN), 32'h0);

    // Asynchronous reset while driving a read
    bus.dWEN[0] = 1'b0;
    #1 chk("t6_pre_ren", 32'(bus.ramREN), 32'h1);
    n_rst = 1'b0;
    #1 chk("t6_rst_ren", 32'(bus.ramREN), 32'h0);
    chk("t6_rst_wen", 32'(bus.ramWEN), 32'h0);
    chk("t6_rst_iwait", 32'(bus.iwait), 32'h3);
    chk("t6_rst_dwait", 32'(bus.dwait), 32'h3);
    n_rst = 1'b1;
    #1 chk("t6_post_idle_ren", 32'(bus.ramREN), 32'h0);
    cyc();
    chk("t6_regrant_ren", 32'(bus.ramREN), 32'h1);
    bus.dREN[0] = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
